uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer in front of the `uart_tx` stage of the `uart` block. A producer (command handler, debug printer) writes bytes at full clock rate into a FIFO. The block drains them one at a time into `uart_tx` using its `i_tx_byte_rdy` / `o_tx_busy` / `o_tx_done` handshake, so the producer never waits one bit period (434 clocks at 115200 baud from 50 MHz) per byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/uart_tx_fifo.sv | 93 +++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART block: byte width, bit timing,
// and the launch sequencer states used by uart_tx_fifo.
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int CLKS_PER_BIT = 434;  // 115200 baud from a 50 MHz clock

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SENDING
    } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered read data, an explicit
// occupancy count, registered full/empty flags and a dropped-write pulse.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             empty_next,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             overflow_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance looks only at the registered flag, so a pop in the same
    // cycle never rescues a write into a full buffer.
    assign wr_ok = wr_en && !full_reg;
    assign rd_ok = rd_en && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem[rd_ptr_reg];
            end
            count_reg    <= count_next;
            full_reg     <= (count_next == FULL_COUNT);
            empty_reg    <= (count_next == '0);
            overflow_reg <= wr_en && full_reg;
        end
    end

    assign rd_data    = rd_data_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign empty_next = (count_next == '0);
    assign count      = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: the producer writes at clock rate, and a
// small launch sequencer feeds one byte at a time through the tx handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [UART_BYTE_W-1:0] i_wr_byte,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [AW:0]            o_count,
    output logic                   o_overflow,
    output logic                   o_tx_byte_rdy,
    output logic [UART_BYTE_W-1:0] o_tx_byte,
    input  logic                   i_tx_busy,
    input  logic                   i_tx_done,
    output logic                   o_idle
);

    tx_fifo_state_t state_reg;
    logic           tx_byte_rdy_reg;
    logic           idle_reg;
    logic           pop;
    logic           empty_next;

    // After a reset mid-frame uart_tx is still busy, so busy gates the launch.
    assign pop = (state_reg == IDLE) && !o_empty && !i_tx_busy;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .wr_en      (i_wr_en),
        .wr_data    (i_wr_byte),
        .rd_en      (pop),
        .rd_data    (o_tx_byte),
        .full       (o_full),
        .empty      (o_empty),
        .empty_next (empty_next),
        .count      (o_count),
        .overflow   (o_overflow)
    );

    // idle_reg tracks the values empty/state take at this same edge, so
    // o_idle always agrees with o_empty and the current state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            tx_byte_rdy_reg <= 1'b0;
            idle_reg        <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg       <= LAUNCH;
                        tx_byte_rdy_reg <= 1'b1;
                        idle_reg        <= 1'b0;
                    end else begin
                        idle_reg <= empty_next;
                    end
                end
                LAUNCH: begin
                    state_reg       <= SENDING;
                    tx_byte_rdy_reg <= 1'b0;
                    idle_reg        <= 1'b0;
                end
                SENDING: begin
                    if (i_tx_done) begin
                        state_reg <= IDLE;
                        idle_reg  <= empty_next;
                    end else begin
                        idle_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    tx_byte_rdy_reg <= 1'b0;
                    idle_reg        <= empty_next;
                end
            endcase
        end
    end

    assign o_tx_byte_rdy = tx_byte_rdy_reg;
    assign o_idle        = idle_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural uart_tx drives a serial line that a
// uart_rx model decodes; launched and received bytes are scoreboarded.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int BIT   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       full, empty, overflow, rdy, idle;
    logic [4:0] count;
    logic [7:0] tx_byte;
    logic       tx_busy, tx_done;

    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       line = 1'b1;
    logic       force_busy = 1'b0;
    logic [9:0] m_shreg = '0;
    int         m_bit = 0;
    int         m_clk = 0;

    assign tx_busy = m_busy | force_busy;
    assign tx_done = m_done;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_byte     (wr_byte),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_overflow    (overflow),
        .o_tx_byte_rdy (rdy),
        .o_tx_byte     (tx_byte),
        .i_tx_busy     (tx_busy),
        .i_tx_done     (tx_done),
        .o_idle        (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] launch_q[$];
    logic [7:0] rx_q[$];
    int rdy_cnt = 0;
    int ovf_cnt = 0;
    logic prev_rdy = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [7:0] b);
        launch_q.push_back(b);
        rx_q.push_back(b);
    endtask

    task automatic write_byte(logic [7:0] b, bit accepted);
        wr_en   = 1'b1;
        wr_byte = b;
        if (accepted) push(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(string name, int max_cycles);
        int n = 0;
        while (!(idle === 1'b1 && !m_busy && rx_q.size() == 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, " idle"}, {31'b0, idle}, 1);
        check({name, " drained"}, rx_q.size(), 0);
    endtask

    // uart_tx stand-in: 8N1 frame, BIT clocks per bit, ignores DUT reset.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!m_busy) begin
            if (rdy === 1'b1) begin
                m_busy  <= 1'b1;
                m_shreg <= {1'b1, tx_byte, 1'b0};
                line    <= 1'b0;
                m_bit   <= 0;
                m_clk   <= 0;
            end
        end else if (m_clk == BIT - 1) begin
            m_clk <= 0;
            if (m_bit == 9) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                line   <= 1'b1;
            end else begin
                m_bit <= m_bit + 1;
                line  <= m_shreg[m_bit + 1];
            end
        end else begin
            m_clk <= m_clk + 1;
        end
    end

    // uart_rx stand-in: mid-bit sampling of the serial line.
    initial begin
        logic [7:0] b;
        logic [7:0] exp_b;
        forever begin
            tick();
            if (line == 1'b0) begin
                repeat (BIT / 2) @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(posedge clk);
                    #1;
                    b[i] = line;
                end
                repeat (BIT) @(posedge clk);
                #1;
                check("rx stop bit", {31'b0, line}, 1);
                if (rx_q.size() == 0) begin
                    check("rx unexpected byte", {24'b0, b}, 32'h100);
                end else begin
                    exp_b = rx_q.pop_front();
                    check("rx byte", {24'b0, b}, {24'b0, exp_b});
                end
            end
        end
    end

    // Launch monitor: every pulse must be one cycle wide and carry the next byte.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            rdy_cnt++;
            check("rdy single cycle", {31'b0, prev_rdy}, 0);
            if (launch_q.size() == 0) begin
                check("unexpected launch", {24'b0, tx_byte}, 32'h100);
            end else begin
                check("launch byte", {24'b0, tx_byte}, {24'b0, launch_q.pop_front()});
            end
        end
        if (overflow === 1'b1) ovf_cnt++;
        prev_rdy = (rdy === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0;
        int rdy0;
        int n;
        int keep;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            wr_en      = 1'($urandom);
            wr_byte    = 8'($urandom);
            force_busy = 1'($urandom);
            tick();
        end
        check("rst full", {31'b0, full}, 0);
        check("rst empty", {31'b0, empty}, 1);
        check("rst count", {27'b0, count}, 0);
        check("rst overflow", {31'b0, overflow}, 0);
        check("rst rdy", {31'b0, rdy}, 0);
        check("rst tx_byte", {24'b0, tx_byte}, 0);
        check("rst idle", {31'b0, idle}, 1);
        wr_en      = 1'b0;
        force_busy = 1'b0;
        rst_n      = 1'b1;
        tick();
        check("post-rst idle", {31'b0, idle}, 1);
        check("post-rst count", {27'b0, count}, 0);

        // Single byte, idle UART
        write_byte(8'hA5, 1'b1);
        check("a5 count", {27'b0, count}, 1);
        check("a5 empty", {31'b0, empty}, 0);
        check("a5 rdy edge k", {31'b0, rdy}, 0);
        tick();
        check("a5 rdy edge k+1", {31'b0, rdy}, 1);
        check("a5 tx_byte", {24'b0, tx_byte}, 32'hA5);
        tick();
        check("a5 rdy edge k+2", {31'b0, rdy}, 0);
        wait_idle("a5", 2000);

        // Burst of 16 while busy, then drain
        force_busy = 1'b1;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        check("burst full", {31'b0, full}, 1);
        check("burst count", {27'b0, count}, 16);
        tick();
        check("burst no overflow", ovf_cnt - ovf0, 0);
        force_busy = 1'b0;
        wait_idle("burst", 3000);
        check("burst last byte", {24'b0, tx_byte}, 32'h0F);

        // 17 writes while busy: the 17th is dropped
        force_busy = 1'b1;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 17; i++) write_byte(8'(i), i < 16);
        check("ovf17 pulse", {31'b0, overflow}, 1);
        check("ovf17 count", {27'b0, count}, 16);
        tick();
        check("ovf17 pulse count", ovf_cnt - ovf0, 1);
        check("ovf17 pulse end", {31'b0, overflow}, 0);
        force_busy = 1'b0;
        wait_idle("ovf17", 3000);
        check("ovf17 last byte", {24'b0, tx_byte}, 32'h0F);

        // Full buffer: launch pop coincides with a write
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i), 1'b1);
        force_busy = 1'b0;
        ovf0 = ovf_cnt;
        write_byte(8'hEE, 1'b0);
        check("pop+wr overflow", {31'b0, overflow}, 1);
        check("pop+wr count", {27'b0, count}, 15);
        check("pop+wr full", {31'b0, full}, 0);
        check("pop+wr rdy", {31'b0, rdy}, 1);
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (full !== 1'b0 && n < 500) begin
                tick();
                n++;
            end
            check("wrap slot free", {31'b0, full}, 0);
            write_byte(8'(8'h40 + i), 1'b1);
        end
        wait_idle("wrap", 6000);
        check("wrap overflow pulses", ovf_cnt - ovf0, 1);
        check("wrap last byte", {24'b0, tx_byte}, 32'h5F);

        // Reset during SENDING with uart_tx still busy
        write_byte(8'h5A, 1'b1);
        write_byte(8'h61, 1'b1);
        write_byte(8'h62, 1'b1);
        repeat (20) tick();
        rst_n      = 1'b0;
        force_busy = 1'b1;
        tick();
        tick();
        keep = rx_q.size() - launch_q.size();
        while (rx_q.size() > keep) void'(rx_q.pop_back());
        launch_q.delete();
        rst_n = 1'b1;
        tick();
        check("midrst empty", {31'b0, empty}, 1);
        check("midrst count", {27'b0, count}, 0);
        check("midrst idle", {31'b0, idle}, 1);
        rdy0 = rdy_cnt;
        write_byte(8'h77, 1'b1);
        repeat (100) tick();
        check("midrst no launch while busy", rdy_cnt - rdy0, 0);
        check("midrst held count", {27'b0, count}, 1);
        force_busy = 1'b0;
        wait_idle("midrst", 2000);
        check("midrst launches", rdy_cnt - rdy0, 1);
        check("midrst last byte", {24'b0, tx_byte}, 32'h77);

        check("launch queue empty", launch_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
